// File: rtl/pulse_sequencer_pkg.sv
// Shared definitions for the pulse sequencer: FSM encoding, default widths and idle pattern.
package pulse_sequencer_pkg;

  localparam int unsigned DUR_W       = 22;
  localparam logic [7:0]  IDLE_PAT    = 8'b1000_0001;
  localparam int unsigned NUM_ENTRIES = 16;
  localparam int unsigned IDX_W       = 4;
  localparam int unsigned PASS_W      = 16;
  localparam int unsigned NSTEP_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Requested step counts above the table depth run the whole table.
  function automatic logic [NSTEP_W-1:0] clamp_steps(input logic [NSTEP_W-1:0] n);
    return (n > NSTEP_W'(NUM_ENTRIES)) ? NSTEP_W'(NUM_ENTRIES) : n;
  endfunction

endpackage

// File: rtl/pulse_sequencer_if.sv
// Configuration, control and status bundle between a host and the pulse sequencer.
interface pulse_sequencer_if #(
  parameter int unsigned DUR_W = pulse_sequencer_pkg::DUR_W
);

  logic             cfg_we;
  logic [3:0]       cfg_addr;
  logic [DUR_W-1:0] cfg_dur;
  logic [7:0]       cfg_pat;
  logic             cfg_trig;
  logic             start;
  logic             stop;
  logic [4:0]       num_steps;
  logic [15:0]      repeat_count;
  logic [7:0]       signal_out;
  logic             trigger;
  logic             busy;
  logic             done;
  logic [3:0]       step_idx;
  logic [15:0]      pass_cnt;

  modport master (
    output cfg_we, cfg_addr, cfg_dur, cfg_pat, cfg_trig,
    output start, stop, num_steps, repeat_count,
    input  signal_out, trigger, busy, done, step_idx, pass_cnt
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_dur, cfg_pat, cfg_trig,
    input  start, stop, num_steps, repeat_count,
    output signal_out, trigger, busy, done, step_idx, pass_cnt
  );

endinterface

// File: rtl/pulse_step_table.sv
// 16-entry step table: one synchronous write port, one combinational read port, no reset.
module pulse_step_table
  import pulse_sequencer_pkg::*;
#(
  parameter int unsigned DUR_W = pulse_sequencer_pkg::DUR_W
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [DUR_W-1:0] wdur_i,
  input  logic [7:0]       wpat_i,
  input  logic             wtrig_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [DUR_W-1:0] rdur_o,
  output logic [7:0]       rpat_o,
  output logic             rtrig_o
);

  logic [DUR_W-1:0] dur_q  [NUM_ENTRIES];
  logic [7:0]       pat_q  [NUM_ENTRIES];
  logic             trig_q [NUM_ENTRIES];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      dur_q[waddr_i]  <= wdur_i;
      pat_q[waddr_i]  <= wpat_i;
      trig_q[waddr_i] <= wtrig_i;
    end
  end

  assign rdur_o  = dur_q[raddr_i];
  assign rpat_o  = pat_q[raddr_i];
  assign rtrig_o = trig_q[raddr_i];

endmodule

// File: rtl/pulse_sequencer.sv
// Table-driven pattern sequencer: steps through num_steps entries, repeating for
// repeat_count passes (or forever), with per-step trigger strobes.
module pulse_sequencer
  import pulse_sequencer_pkg::*;
#(
  parameter int unsigned DUR_W    = pulse_sequencer_pkg::DUR_W,
  parameter logic [7:0]  IDLE_PAT = pulse_sequencer_pkg::IDLE_PAT
) (
  input  logic           clk_in,
  input  logic           rst_in,
  pulse_sequencer_if.slave bus
);

  state_t              state_q;
  logic [7:0]          signal_out_q;
  logic                trigger_q;
  logic                busy_q;
  logic                done_q;
  logic [IDX_W-1:0]    step_idx_q;
  logic [PASS_W-1:0]   pass_cnt_q;
  logic [PASS_W-1:0]   rep_q;
  logic [NSTEP_W-1:0]  n_steps_q;
  logic [DUR_W-1:0]    timer_q;

  logic [IDX_W-1:0]    rd_addr;
  logic [DUR_W-1:0]    rd_dur;
  logic [7:0]          rd_pat;
  logic                rd_trig;
  logic [DUR_W-1:0]    rd_timer;
  logic [NSTEP_W-1:0]  n_clamped;
  logic [PASS_W-1:0]   pass_inc;
  logic                last_step;
  logic                step_end;
  logic                tbl_we;

  assign tbl_we    = bus.cfg_we && (state_q == ST_IDLE);
  assign n_clamped = clamp_steps(bus.num_steps);
  assign last_step = (NSTEP_W'(step_idx_q) + NSTEP_W'(1)) == n_steps_q;
  assign step_end  = (timer_q == '0);
  assign pass_inc  = pass_cnt_q + PASS_W'(1);

  // The read port always points at the entry that the next step load will use.
  assign rd_addr  = ((state_q == ST_RUN) && !last_step) ? step_idx_q + IDX_W'(1) : '0;
  assign rd_timer = (rd_dur == '0) ? '0 : rd_dur - DUR_W'(1);

  pulse_step_table #(.DUR_W(DUR_W)) u_table (
    .clk_i   (clk_in),
    .we_i    (tbl_we),
    .waddr_i (bus.cfg_addr),
    .wdur_i  (bus.cfg_dur),
    .wpat_i  (bus.cfg_pat),
    .wtrig_i (bus.cfg_trig),
    .raddr_i (rd_addr),
    .rdur_o  (rd_dur),
    .rpat_o  (rd_pat),
    .rtrig_o (rd_trig)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      signal_out_q <= IDLE_PAT;
      trigger_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      step_idx_q   <= '0;
      pass_cnt_q   <= '0;
      rep_q        <= '0;
      n_steps_q    <= '0;
      timer_q      <= '0;
    end else begin
      trigger_q <= 1'b0;
      done_q    <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start && !bus.stop && (n_clamped != '0)) begin
            state_q      <= ST_RUN;
            n_steps_q    <= n_clamped;
            rep_q        <= bus.repeat_count;
            pass_cnt_q   <= '0;
            step_idx_q   <= '0;
            timer_q      <= rd_timer;
            signal_out_q <= rd_pat;
            trigger_q    <= rd_trig;
            busy_q       <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.stop) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            signal_out_q <= IDLE_PAT;
            timer_q      <= '0;
          end else if (!step_end) begin
            timer_q <= timer_q - DUR_W'(1);
          end else begin
            if (last_step) pass_cnt_q <= pass_inc;
            if (last_step && (rep_q != '0) && (pass_inc == rep_q)) begin
              state_q      <= ST_DONE;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              signal_out_q <= IDLE_PAT;
            end else begin
              step_idx_q   <= last_step ? '0 : step_idx_q + IDX_W'(1);
              timer_q      <= rd_timer;
              signal_out_q <= rd_pat;
              trigger_q    <= rd_trig;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.signal_out = signal_out_q;
  assign bus.trigger    = trigger_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.step_idx   = step_idx_q;
  assign bus.pass_cnt   = pass_cnt_q;

endmodule
